// File: rtl/rdma_cmplt_tracker.sv
// In-order tracker of outstanding RDMA requests, retired against cumulative rdma_ack_t acks.
// Optional statistics counters are built when RDMA_CMPLT_STATS_EN is defined.
module rdma_cmplt_tracker #(
  parameter int N_OUTSTANDING = 32,
  parameter int SSN_BITS      = 24,
  parameter int PID_BITS      = 6
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             s_req_valid,
  output logic                             s_req_ready,
  input  logic [SSN_BITS-1:0]              s_req_ssn,
  input  logic [PID_BITS-1:0]              s_req_pid,
  input  logic                             s_req_rd,
  input  logic                             s_ack_valid,
  output logic                             s_ack_ready,
  input  logic [35:0]                      s_ack_data,
  output logic                             m_cmpl_valid,
  input  logic                             m_cmpl_ready,
  output logic [SSN_BITS-1:0]              m_cmpl_ssn,
  output logic [PID_BITS-1:0]              m_cmpl_pid,
  output logic                             m_cmpl_rd,
  output logic                             m_cmpl_last,
  output logic                             m_cmpl_err,
  output logic [$clog2(N_OUTSTANDING):0]   outstanding,
  output logic                             err_spurious,
  output logic                             err_range,
  output logic [31:0]                      stat_cmpl_cnt,
  output logic [31:0]                      stat_err_cnt
);

  localparam int AW = $clog2(N_OUTSTANDING);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RETIRE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d, count_pop_s;
  logic [SSN_BITS-1:0] ssn_mem [N_OUTSTANDING];
  logic [PID_BITS-1:0] pid_mem [N_OUTSTANDING];
  logic                rd_mem  [N_OUTSTANDING];

  logic [SSN_BITS-1:0] target_q;
  logic                tgt_rd_q;
  logic                cmpl_valid_q, cmpl_rd_q, cmpl_last_q, cmpl_err_q;
  logic [SSN_BITS-1:0] cmpl_ssn_q;
  logic [PID_BITS-1:0] cmpl_pid_q;
  logic                err_spurious_q, err_range_q;

  logic                push_s, pop_s, ack_fire_s, empty_s;
  logic                ack_cmplt_s, ack_rd_s;
  logic [SSN_BITS-1:0] ack_ssn_s, head_ssn_s, tail_ssn_s, dist_ack_s, dist_tail_s;
  logic                spurious_s, range_s, start_s, retire_end_s;
  logic [AW-1:0]       load_idx_s;
  logic [SSN_BITS-1:0] load_ssn_s, load_tgt_s;
  logic                load_rd_s, load_tgt_rd_s, load_last_s;
  logic                ack_unused_s;

  assign ack_cmplt_s  = s_ack_data[34];
  assign ack_rd_s     = s_ack_data[35];
  assign ack_ssn_s    = s_ack_data[SSN_BITS-1:0];
  assign ack_unused_s = ^s_ack_data[33:SSN_BITS];

  assign push_s      = s_req_valid && s_req_ready;
  assign pop_s       = cmpl_valid_q && m_cmpl_ready;
  assign ack_fire_s  = s_ack_valid && s_ack_ready;
  assign empty_s     = (count_q == {CW{1'b0}});
  assign count_pop_s = count_q - {{(CW-1){1'b0}}, pop_s};
  assign s_req_ready = (count_pop_s != CW'(N_OUTSTANDING));

  // Range check is taken on registered FIFO contents, so a same-cycle push is never eligible.
  assign head_ssn_s  = ssn_mem[head_q];
  assign tail_ssn_s  = ssn_mem[tail_q - AW'(1)];
  assign dist_ack_s  = ack_ssn_s - head_ssn_s;
  assign dist_tail_s = tail_ssn_s - head_ssn_s;

  assign spurious_s = ack_fire_s && ack_cmplt_s && empty_s;
  assign range_s    = ack_fire_s && ack_cmplt_s && !empty_s && (dist_ack_s > dist_tail_s);
  assign start_s    = ack_fire_s && ack_cmplt_s && !empty_s && !(dist_ack_s > dist_tail_s);

  // Retirement also stops if the FIFO would drain, guarding against an ack ssn that falls in a gap.
  assign retire_end_s = pop_s && (cmpl_last_q || (count_pop_s == {CW{1'b0}}));

  assign load_idx_s    = start_s ? head_q : (head_q + AW'(1));
  assign load_ssn_s    = ssn_mem[load_idx_s];
  assign load_rd_s     = rd_mem[load_idx_s];
  assign load_tgt_s    = start_s ? ack_ssn_s : target_q;
  assign load_tgt_rd_s = start_s ? ack_rd_s : tgt_rd_q;
  assign load_last_s   = (load_ssn_s == load_tgt_s);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_s ? ST_RETIRE : ST_IDLE;
      ST_RETIRE: state_d = retire_end_s ? ST_IDLE : ST_RETIRE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ack_ready = 1'b0;
    case (state_q)
      ST_IDLE:   s_ack_ready = 1'b1;
      ST_RETIRE: s_ack_ready = 1'b0;
      default:   s_ack_ready = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push_s) begin
      ssn_mem[tail_q] <= s_req_ssn;
      pid_mem[tail_q] <= s_req_pid;
      rd_mem[tail_q]  <= s_req_rd;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
      if (push_s) tail_q <= tail_q + AW'(1);
      if (pop_s)  head_q <= head_q + AW'(1);
    end
  end

  // Completion register: loaded from head on ack start, from head+1 on each non-final pop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      target_q     <= {SSN_BITS{1'b0}};
      tgt_rd_q     <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_ssn_q   <= {SSN_BITS{1'b0}};
      cmpl_pid_q   <= {PID_BITS{1'b0}};
      cmpl_rd_q    <= 1'b0;
      cmpl_last_q  <= 1'b0;
      cmpl_err_q   <= 1'b0;
    end else if (start_s || (pop_s && !retire_end_s)) begin
      target_q     <= load_tgt_s;
      tgt_rd_q     <= load_tgt_rd_s;
      cmpl_valid_q <= 1'b1;
      cmpl_ssn_q   <= load_ssn_s;
      cmpl_pid_q   <= pid_mem[load_idx_s];
      cmpl_rd_q    <= load_rd_s;
      cmpl_last_q  <= load_last_s;
      cmpl_err_q   <= load_last_s && (load_rd_s != load_tgt_rd_s);
    end else if (retire_end_s) begin
      cmpl_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_spurious_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      if (spurious_s) err_spurious_q <= 1'b1;
      if (range_s)    err_range_q    <= 1'b1;
    end
  end

  assign m_cmpl_valid = cmpl_valid_q;
  assign m_cmpl_ssn   = cmpl_ssn_q;
  assign m_cmpl_pid   = cmpl_pid_q;
  assign m_cmpl_rd    = cmpl_rd_q;
  assign m_cmpl_last  = cmpl_last_q;
  assign m_cmpl_err   = cmpl_err_q;
  assign outstanding  = count_q;
  assign err_spurious = err_spurious_q;
  assign err_range    = err_range_q;

`ifdef RDMA_CMPLT_STATS_EN
  logic [31:0] stat_cmpl_q, stat_err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_cmpl_q <= 32'd0;
      stat_err_q  <= 32'd0;
    end else begin
      if (pop_s)                   stat_cmpl_q <= stat_cmpl_q + 32'd1;
      if (spurious_s || range_s)   stat_err_q  <= stat_err_q + 32'd1;
    end
  end

  assign stat_cmpl_cnt = stat_cmpl_q;
  assign stat_err_cnt  = stat_err_q;
`else
  assign stat_cmpl_cnt = 32'd0;
  assign stat_err_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_rdma_cmplt_tracker.sv
// Scoreboard bench for rdma_cmplt_tracker: directed stimulus queues expected completions,
// a negedge monitor pops and compares them on every completion handshake.
module tb_rdma_cmplt_tracker;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_req_valid, s_req_ready, s_req_rd;
  logic [23:0] s_req_ssn;
  logic [5:0]  s_req_pid;
  logic        s_ack_valid, s_ack_ready;
  logic [35:0] s_ack_data;
  logic        m_cmpl_valid, m_cmpl_ready, m_cmpl_rd, m_cmpl_last, m_cmpl_err;
  logic [23:0] m_cmpl_ssn;
  logic [5:0]  m_cmpl_pid;
  logic [5:0]  outstanding;
  logic        err_spurious, err_range;
  logic [31:0] stat_cmpl_cnt, stat_err_cnt;

  typedef struct packed {
    logic [23:0] ssn;
    logic [5:0]  pid;
    logic        rd;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  rdma_cmplt_tracker dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_ssn(s_req_ssn), .s_req_pid(s_req_pid), .s_req_rd(s_req_rd),
    .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_data(s_ack_data),
    .m_cmpl_valid(m_cmpl_valid), .m_cmpl_ready(m_cmpl_ready),
    .m_cmpl_ssn(m_cmpl_ssn), .m_cmpl_pid(m_cmpl_pid), .m_cmpl_rd(m_cmpl_rd),
    .m_cmpl_last(m_cmpl_last), .m_cmpl_err(m_cmpl_err),
    .outstanding(outstanding), .err_spurious(err_spurious), .err_range(err_range),
    .stat_cmpl_cnt(stat_cmpl_cnt), .stat_err_cnt(stat_err_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!areset && m_cmpl_valid && m_cmpl_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmpl actual ssn=%0h required none", m_cmpl_ssn);
      end else begin
        mon_e = sb_q.pop_front();
        chk("cmpl", 64'({m_cmpl_ssn, m_cmpl_pid, m_cmpl_rd, m_cmpl_last, m_cmpl_err}), 64'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [23:0] ssn, input logic [5:0] pid, input logic rd);
    int n = 0;
    s_req_ssn = ssn; s_req_pid = pid; s_req_rd = rd; s_req_valid = 1'b1;
    while (!s_req_ready && n < 50) begin tick(); n++; end
    if (!s_req_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout actual ready=0 required ready=1");
    end
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic send_ack(input logic rd, input logic cmplt, input logic [23:0] ssn);
    int n = 0;
    s_ack_data  = {rd, cmplt, 6'h2A, 4'h5, ssn};
    s_ack_valid = 1'b1;
    while (!s_ack_ready && n < 50) begin tick(); n++; end
    if (!s_ack_ready) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual ready=0 required ready=1");
    end
    tick();
    s_ack_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!s_ack_ready && cycles < 100) begin tick(); cycles++; end
    if (!s_ack_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual ack_ready=0 required 1");
    end
  endtask

  function automatic exp_t mk(input logic [23:0] ssn, input logic [5:0] pid,
                              input logic rd, input logic last, input logic err);
    mk = '{ssn: ssn, pid: pid, rd: rd, last: last, err: err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [23:0] s;
    areset = 1'b1; s_req_valid = 1'b0; s_req_ssn = 24'd0; s_req_pid = 6'd0; s_req_rd = 1'b0;
    s_ack_valid = 1'b0; s_ack_data = 36'd0; m_cmpl_ready = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    // reset state
    chk("rst_valid", 64'(m_cmpl_valid), 64'd0);
    chk("rst_req_ready", 64'(s_req_ready), 64'd1);
    chk("rst_ack_ready", 64'(s_ack_ready), 64'd1);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_errs", 64'({err_spurious, err_range}), 64'd0);
    chk("rst_stats", 64'({stat_cmpl_cnt, stat_err_cnt}), 64'd0);

    // single request
    push(24'd5, 6'd1, 1'b0);
    chk("single_outstanding", 64'(outstanding), 64'd1);
    sb_q.push_back(mk(24'd5, 6'd1, 1'b0, 1'b1, 1'b0));
    send_ack(1'b0, 1'b1, 24'd5);
    chk("single_latency", 64'(m_cmpl_valid), 64'd1);
    tick();
    chk("single_outstanding_end", 64'(outstanding), 64'd0);
    chk("single_ack_ready", 64'(s_ack_ready), 64'd1);

    // cumulative ack
    push(24'd10, 6'd2, 1'b1);
    push(24'd11, 6'd3, 1'b0);
    push(24'd12, 6'd4, 1'b1);
    sb_q.push_back(mk(24'd10, 6'd2, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(mk(24'd11, 6'd3, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(24'd12, 6'd4, 1'b1, 1'b1, 1'b0));
    send_ack(1'b1, 1'b1, 24'd12);
    wait_idle(cyc);
    chk("cumul_ack_low_cycles", 64'(cyc), 64'd3);
    chk("cumul_outstanding", 64'(outstanding), 64'd0);

    // cmplt=0 ack on empty FIFO is consumed silently
    send_ack(1'b0, 1'b0, 24'd7);
    chk("noncmplt_no_spurious", 64'(err_spurious), 64'd0);
    chk("noncmplt_no_cmpl", 64'(m_cmpl_valid), 64'd0);

    // spurious ack
    send_ack(1'b0, 1'b1, 24'd7);
    chk("spurious_flag", 64'(err_spurious), 64'd1);
    chk("spurious_ack_ready", 64'(s_ack_ready), 64'd1);

    // out-of-range ack leaves FIFO intact
    push(24'd10, 6'd5, 1'b0);
    push(24'd11, 6'd6, 1'b0);
    push(24'd12, 6'd7, 1'b0);
    send_ack(1'b0, 1'b1, 24'd20);
    chk("range_flag", 64'(err_range), 64'd1);
    chk("range_outstanding", 64'(outstanding), 64'd3);
    chk("range_no_cmpl", 64'(m_cmpl_valid), 64'd0);
`ifdef RDMA_CMPLT_STATS_EN
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'd2);
`else
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'd0);
`endif
    sb_q.push_back(mk(24'd10, 6'd5, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(24'd11, 6'd6, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(24'd12, 6'd7, 1'b0, 1'b1, 1'b0));
    send_ack(1'b0, 1'b1, 24'd12);
    wait_idle(cyc);
    chk("range_drain_outstanding", 64'(outstanding), 64'd0);

    // backpressure with rd mismatch
    m_cmpl_ready = 1'b0;
    push(24'd3, 6'd9, 1'b1);
    send_ack(1'b0, 1'b1, 24'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 64'({m_cmpl_valid, m_cmpl_ssn, m_cmpl_pid, m_cmpl_rd, m_cmpl_last, m_cmpl_err}),
          64'({1'b1, 24'd3, 6'd9, 1'b1, 1'b1, 1'b1}));
      tick();
    end
    sb_q.push_back(mk(24'd3, 6'd9, 1'b1, 1'b1, 1'b1));
    m_cmpl_ready = 1'b1;
    tick();
    chk("bp_ack_ready_after", 64'(s_ack_ready), 64'd1);

    // full FIFO with ssn wrap
    for (int i = 0; i < 32; i++) begin
      s = 24'hFFFFF0 + 24'(i);
      push(s, 6'(i), i[0]);
    end
    chk("full_req_ready", 64'(s_req_ready), 64'd0);
    chk("full_outstanding", 64'(outstanding), 64'd32);
    for (int i = 0; i < 19; i++) begin
      s = 24'hFFFFF0 + 24'(i);
      sb_q.push_back(mk(s, 6'(i), i[0], (i == 18), 1'b0));
    end
    send_ack(1'b0, 1'b1, 24'h000002);
    chk("full_ready_same_cycle_pop", 64'(s_req_ready), 64'd1);
    wait_idle(cyc);
    chk("wrap_retire_cycles", 64'(cyc), 64'd19);
    chk("wrap_outstanding", 64'(outstanding), 64'd13);
    chk("wrap_req_ready", 64'(s_req_ready), 64'd1);
    for (int i = 19; i < 32; i++) begin
      s = 24'hFFFFF0 + 24'(i);
      sb_q.push_back(mk(s, 6'(i), i[0], (i == 31), 1'b0));
    end
    send_ack(1'b1, 1'b1, 24'h00000F);
    wait_idle(cyc);
    chk("wrap_drain_outstanding", 64'(outstanding), 64'd0);
`ifdef RDMA_CMPLT_STATS_EN
    chk("stat_cmpl_cnt", 64'(stat_cmpl_cnt), 64'd40);
`else
    chk("stat_cmpl_cnt", 64'(stat_cmpl_cnt), 64'd0);
`endif

    // reset mid-retirement
    push(24'd40, 6'd1, 1'b0);
    push(24'd41, 6'd2, 1'b0);
    push(24'd42, 6'd3, 1'b0);
    sb_q.push_back(mk(24'd40, 6'd1, 1'b0, 1'b0, 1'b0));
    send_ack(1'b0, 1'b1, 24'd42);
    tick();
    areset = 1'b1;
    tick();
    chk("midrst_valid", 64'(m_cmpl_valid), 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_readies", 64'({s_req_ready, s_ack_ready}), 64'd3);
    chk("midrst_errs", 64'({err_spurious, err_range}), 64'd0);
    chk("midrst_stats", 64'({stat_cmpl_cnt, stat_err_cnt}), 64'd0);
    chk("midrst_fields", 64'({m_cmpl_ssn, m_cmpl_pid, m_cmpl_rd, m_cmpl_last, m_cmpl_err}), 64'd0);
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_cmpl", 64'(m_cmpl_valid), 64'd0);
    end
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
